mapper_ss_engine: RTL
=====================

MAPPER_SS_ENGINE -- requirements
Module: mapper_ss_engine

Interface
REQ-001 SHALL have parameter REG_CNT, default 128: count of mapper save-state slots, addresses 0..REG_CNT-1; slot REG_CNT-1 is the read-only mapper index.
REQ-002 SHALL have parameter TMO, default 1024: clk cycles allowed per write before timeout.
REQ-003 SHALL have ports in this order:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m2  in  1  CPU M2, asynchronous to clk.
- save_req  in  1  one-cycle save start.
- load_req  in  1  one-cycle restore start.
- abort  in  1  cancel the current operation.
- ss_act  out  1  save-state access active, to the mapper.
- ss_we  out  1  slot write strobe, to the mapper.
- ss_addr  out  8  slot address.
- ss_wdat  out  8  write data, muxed onto the mapper data bus.
- ss_rdat  in  8  mapper combinational read data.
- out_dat  out  8  saved byte to host.
- out_valid  out  1  saved byte valid.
- out_ready  in  1  host accepts saved byte.
- in_dat  in  8  restore byte from host.
- in_valid  in  1  restore byte valid.
- in_ready  out  1  engine accepts restore byte.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err_tmo  out  1  sticky M2 timeout.
- err_idx  out  1  sticky mapper-index mismatch.
REQ-004 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.

Function
REQ-005 SHALL synchronise m2 through 2 flops and produce a one-cycle m2_fall pulse on each detected 1->0 transition.
REQ-006 SHALL use states IDLE, SV_SET, SV_SAMP, SV_OUT, LD_GET, LD_WR, LD_IDX, FIN.
REQ-007 IDLE: save_req -> SV_SET with ss_addr=0; load_req -> LD_GET with ss_addr=0; save_req wins if both are high; requests while busy are ignored.
REQ-008 ss_act SHALL be 1 in every state except IDLE; busy SHALL equal ss_act.
REQ-009 SV_SET: hold ss_addr one cycle for settling -> SV_SAMP.
REQ-010 SV_SAMP: latch ss_rdat into out_dat, set out_valid -> SV_OUT.
REQ-011 SV_OUT: on out_valid & out_ready, clear out_valid; if ss_addr=REG_CNT-1 -> FIN, else increment ss_addr -> SV_SET.
REQ-012 out_dat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-013 LD_GET: in_ready=1; on in_valid & in_ready, latch in_dat:
- if ss_addr<REG_CNT-1: latch into ss_wdat -> LD_WR.
- if ss_addr=REG_CNT-1: latch as the expected index -> LD_IDX.
REQ-014 LD_WR: assert ss_we and hold ss_addr/ss_wdat until the first m2_fall, deassert ss_we the next cycle, increment ss_addr -> LD_GET.
REQ-015 LD_WR timeout: if no m2_fall arrives within TMO cycles of entry, set err_tmo, drop ss_we -> FIN.
REQ-016 LD_IDX: never writes; compares the latched index with ss_rdat; on mismatch sets err_idx -> FIN.
REQ-017 FIN: pulse done for one cycle, deassert ss_act -> IDLE.
REQ-018 abort in any non-IDLE state -> FIN next cycle; ss_we, out_valid and in_ready all drop that cycle.
REQ-019 abort in IDLE SHALL have no effect.
REQ-020 err_tmo and err_idx SHALL clear on the next accepted save_req or load_req.
REQ-021 ss_addr SHALL never exceed REG_CNT-1; there is no wrap-around within an operation.
REQ-022 in_ready SHALL be 0 outside LD_GET.

Reset
REQ-023 While rst_n=0: state=IDLE, ss_addr=0, ss_wdat=0, out_dat=0, and every 1-bit output and synchroniser flop =0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation with no done pulse, and ss_we SHALL drop immediately.

Structure
REQ-025 The state enumeration, the index-slot constant 127 and the default TMO SHALL live in a shared package, alongside the existing save-state address definitions.
REQ-026 The m2 synchroniser and edge detector SHALL be a separate sub-module, m2_edge_sync.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Save with mapper model prg=5, chr0=0x11, chr1=0x1F, idx=34, out_ready always 1 -> 128 bytes; byte0=05, byte1=11, byte2=1F, bytes3..126=FF, byte127=22; done pulses once.
- Load stream 07,03,04,FF..., index 34, m2 at 1.79 MHz -> model prg=7, chr0=3, chr1=4; ss_we never high for slot 127; err_idx=0.
- Load with m2 held high -> err_tmo=1 after 1024 cycles at slot 0; done pulses; ss_we=0.
- Load with index byte 33 while the mapper index is 34 -> err_idx=1; slots 0..126 are still written.
- Save with out_ready toggling 1-of-3 cycles, plus abort at slot 50 -> out_dat stable while stalled; FIN within 1 cycle of abort; no further ss_addr change.
- rst_n pulsed low during LD_WR -> ss_we=0 asynchronously; state IDLE; no done pulse.

Source files
------------

// File: rtl/mapper_ss_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mapper_ss_engine_pkg                                            |
// | Brief    : Save-state slot map, engine states and shared constants.        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package mapper_ss_engine_pkg;

    localparam logic [7:0] SS_ADDR_PRG    = 8'd0;
    localparam logic [7:0] SS_ADDR_CHR0   = 8'd1;
    localparam logic [7:0] SS_ADDR_CHR1   = 8'd2;
    localparam int         SS_IDX_SLOT    = 127;
    localparam int         SS_TMO_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SV_SET  = 3'd1,
        SV_SAMP = 3'd2,
        SV_OUT  = 3'd3,
        LD_GET  = 3'd4,
        LD_WR   = 3'd5,
        LD_IDX  = 3'd6,
        FIN     = 3'd7
    } ss_state_e;

endpackage
`default_nettype wire

// File: rtl/mapper_ss_engine_m2_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : m2_edge_sync                                                    |
// | Brief    : Two-flop synchroniser for CPU M2 with falling-edge pulse.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module m2_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic m2,
    output logic m2_fall
);

    logic sync1_q, sync2_q, dly_q;
    logic sync1_d, sync2_d, dly_d;

    always_comb begin
        sync1_d = m2;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    // Edge taken only between fully synchronised stages.
    assign m2_fall = dly_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/mapper_ss_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mapper_ss_engine                                                |
// | Brief    : Streams mapper save-state slots out to a host and back in.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mapper_ss_engine
    import mapper_ss_engine_pkg::*;
#(
    parameter int REG_CNT = SS_IDX_SLOT + 1,
    parameter int TMO     = SS_TMO_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       save_req,
    input  logic       load_req,
    input  logic       abort,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] out_dat,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_dat,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       err_tmo,
    output logic       err_idx
);

    localparam int             TW        = $clog2(TMO + 1);
    localparam logic [7:0]     ADDR_LAST = 8'(REG_CNT - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO - 1);

    logic m2_fall;

    m2_edge_sync u_m2_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .m2      (m2),
        .m2_fall (m2_fall)
    );

    ss_state_e     state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic [7:0]    out_dat_q, out_dat_d;
    logic [7:0]    idx_exp_q, idx_exp_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_idx_q, err_idx_d;
    logic          act_q, act_d;
    logic          we_q, we_d;
    logic          in_ready_q, in_ready_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        out_dat_d   = out_dat_q;
        idx_exp_d   = idx_exp_q;
        tmo_cnt_d   = tmo_cnt_q;
        out_valid_d = out_valid_q;
        err_tmo_d   = err_tmo_q;
        err_idx_d   = err_idx_q;

        unique case (state_q)
            IDLE: begin
                if (save_req || load_req) begin
                    state_d   = save_req ? SV_SET : LD_GET;
                    addr_d    = 8'd0;
                    err_tmo_d = 1'b0;
                    err_idx_d = 1'b0;
                end
            end
            SV_SET:  state_d = SV_SAMP;
            SV_SAMP: begin
                out_dat_d   = ss_rdat;
                out_valid_d = 1'b1;
                state_d     = SV_OUT;
            end
            SV_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = SV_SET;
                    end
                end
            end
            LD_GET: begin
                if (in_valid && in_ready_q) begin
                    if (addr_q == ADDR_LAST) begin
                        idx_exp_d = in_dat;
                        state_d   = LD_IDX;
                    end else begin
                        wdat_d    = in_dat;
                        tmo_cnt_d = '0;
                        state_d   = LD_WR;
                    end
                end
            end
            LD_WR: begin
                // Address and data stay put until the mapper has clocked them on M2 fall.
                if (m2_fall) begin
                    addr_d  = addr_q + 8'd1;
                    state_d = LD_GET;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            LD_IDX: begin
                if (idx_exp_q != ss_rdat) begin
                    err_idx_d = 1'b1;
                end
                state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE) && (state_q != FIN)) begin
            state_d     = FIN;
            out_valid_d = 1'b0;
        end

        act_d      = (state_d != IDLE);
        we_d       = (state_d == LD_WR);
        in_ready_d = (state_d == LD_GET);
        done_d     = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 8'd0;
            wdat_q      <= 8'd0;
            out_dat_q   <= 8'd0;
            idx_exp_q   <= 8'd0;
            tmo_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_idx_q   <= 1'b0;
            act_q       <= 1'b0;
            we_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            out_dat_q   <= out_dat_d;
            idx_exp_q   <= idx_exp_d;
            tmo_cnt_q   <= tmo_cnt_d;
            out_valid_q <= out_valid_d;
            err_tmo_q   <= err_tmo_d;
            err_idx_q   <= err_idx_d;
            act_q       <= act_d;
            we_q        <= we_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
        end
    end

    assign ss_act    = act_q;
    assign busy      = act_q;
    assign ss_we     = we_q;
    assign ss_addr   = addr_q;
    assign ss_wdat   = wdat_q;
    assign out_dat   = out_dat_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign err_tmo   = err_tmo_q;
    assign err_idx   = err_idx_q;

endmodule
`default_nettype wire
